// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage
// Elastic pipeline register between decode and execute/memory.
// A STAGES-deep chain of slots, each with its own valid bit, moves beats
// forward under a per-beat valid/ready handshake. Empty slots (bubbles)
// collapse even while downstream is stalled. A synchronous flush squashes
// every in-flight beat.
// Optional feature: define PIPE_ELASTIC_STAGE_SKID_EN to put a one-entry
// skid register ahead of slot 0. in_ready then becomes a register output
// and no longer depends combinationally on out_ready.
module pipe_elastic_stage #(
   parameter int DATA_W = 64,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:DATA_W-1] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:DATA_W-1] out_data,
   output logic [0:2]        occupancy
);

   // Slot state; slot STAGES-1 holds the oldest beat and drives the output.
   logic              v      [STAGES];
   logic [0:DATA_W-1] d      [STAGES];
   logic              v_next [STAGES];
   logic [0:DATA_W-1] d_next [STAGES];

   // accept[i] is high when slot i may load this cycle (it is empty, or its
   // beat leaves because everything downstream of it is moving).
   logic              accept [STAGES];

   // chain_*[0] is the source feeding slot 0; chain_*[i+1] mirrors slot i,
   // so slot i always loads from chain_*[i].
   logic              chain_v [STAGES+1];
   logic [0:DATA_W-1] chain_d [STAGES+1];

   logic              src_v;
   logic [0:DATA_W-1] src_d;
   logic              in_fire;
   logic [2:0]        occ_next;

`ifdef PIPE_ELASTIC_STAGE_SKID_EN
   logic              skid_v;
   logic [0:DATA_W-1] skid_d;
   logic              skid_v_next;
   logic [0:DATA_W-1] skid_d_next;
`endif

   // Walk from the output back toward the input to find which slots can load.
   always_comb begin
      logic hole;
      hole = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         hole      = hole || !v[i];
         accept[i] = hole;
      end
   end

`ifdef PIPE_ELASTIC_STAGE_SKID_EN
   // A parked skid beat has priority over new input; in_ready is purely registered.
   always_comb begin
      in_ready = !skid_v && !flush && !reset;
      in_fire  = in_valid && in_ready;
      src_v    = skid_v || in_fire;
      src_d    = skid_v ? skid_d : in_data;
   end
`else
   // Without the skid, input can be taken whenever any slot frees up this cycle.
   always_comb begin
      in_ready = accept[0] && !flush && !reset;
      in_fire  = in_valid && in_ready;
      src_v    = in_fire;
      src_d    = in_data;
   end
`endif

   // Build the source-plus-slots view so every slot has a predecessor.
   always_comb begin
      chain_v[0] = src_v;
      chain_d[0] = src_d;
      for (int i = 0; i < STAGES; i++) begin
         chain_v[i+1] = v[i];
         chain_d[i+1] = d[i];
      end
   end

   // Advance loading slots; data only moves with a valid beat, flush clears valids.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         v_next[i] = v[i];
         d_next[i] = d[i];
         if (accept[i]) begin
            v_next[i] = chain_v[i];
            if (chain_v[i]) begin
               d_next[i] = chain_d[i];
            end
         end
         if (flush) begin
            v_next[i] = 1'b0;
         end
      end
   end

`ifdef PIPE_ELASTIC_STAGE_SKID_EN
   // Park an accepted beat when slot 0 cannot take it; release once slot 0 loads.
   always_comb begin
      skid_v_next = skid_v;
      skid_d_next = skid_d;
      if (skid_v) begin
         skid_v_next = !accept[0];
      end else if (in_fire && !accept[0]) begin
         skid_v_next = 1'b1;
         skid_d_next = in_data;
      end
      if (flush) begin
         skid_v_next = 1'b0;
      end
   end
`endif

   // Count beats that will be held after the coming edge.
   always_comb begin
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < STAGES; i++) begin
         if (v_next[i]) begin
            cnt = cnt + 1;
         end
      end
`ifdef PIPE_ELASTIC_STAGE_SKID_EN
      if (skid_v_next) begin
         cnt = cnt + 1;
      end
`endif
      occ_next = 3'(cnt);
   end

   // Register slot state and occupancy; reset clears valids and data.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            v[i] <= 1'b0;
            d[i] <= '0;
         end
         occupancy <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            v[i] <= v_next[i];
            d[i] <= d_next[i];
         end
         occupancy <= occ_next;
      end
   end

`ifdef PIPE_ELASTIC_STAGE_SKID_EN
   // Register the skid entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         skid_v <= 1'b0;
         skid_d <= '0;
      end else begin
         skid_v <= skid_v_next;
         skid_d <= skid_d_next;
      end
   end
`endif

   assign out_valid = v[STAGES-1];
   assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// tb_pipe_elastic_stage
// Scoreboard bench for pipe_elastic_stage. The reference model is a FIFO of
// accepted beats: every accepted beat must come out once, in order, with the
// same data, and occupancy must equal the number of beats held.
module tb_pipe_elastic_stage;

   localparam int DATA_W = 64;
   localparam int STAGES = 3;
`ifdef PIPE_ELASTIC_STAGE_SKID_EN
   localparam int CAP = STAGES + 1;
   localparam bit SKID = 1'b1;
`else
   localparam int CAP = STAGES;
   localparam bit SKID = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [0:DATA_W-1] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [0:DATA_W-1] out_data;
   logic [0:2]        occupancy;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   bit streaming_check = 1'b0;

   logic [0:DATA_W-1] exp_q [$];
   int                acc_q [$];

   logic              prev_stall = 1'b0;
   logic [0:DATA_W-1] prev_data;

   pipe_elastic_stage #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [0:DATA_W-1] dat, input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = dat;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Monitor: compare against the FIFO model before each edge, then update it.
   always @(negedge clk) begin
      logic exp_ready;
      int   age;
      cycle++;
      if (reset) begin
         checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
         checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
         checkOutput("reset_out_data", 64'(out_data), 64'd0);
         checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
         exp_q.delete();
         acc_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (SKID) exp_ready = !flush && (exp_q.size() < CAP);
         else      exp_ready = !flush && ((exp_q.size() < CAP) || out_ready);
         checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
         checkOutput("occupancy", 64'(occupancy), 64'(exp_q.size()));
         if (prev_stall) begin
            checkOutput("stall_valid_stable", 64'(out_valid), 64'd1);
            checkOutput("stall_data_stable", 64'(out_data), 64'(prev_data));
         end
         if (out_valid && exp_q.size() == 0) begin
            checkOutput("spurious_out_valid", 64'(out_valid), 64'd0);
         end
         if (flush) begin
            exp_q.delete();
            acc_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
               age = cycle - acc_q[0];
               checkOutput("out_data", 64'(out_data), 64'(exp_q[0]));
               if (age < STAGES) checkOutput("min_latency", 64'(age), 64'(STAGES));
               if (streaming_check) checkOutput("stream_latency", 64'(age), 64'(STAGES));
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(in_data);
               acc_q.push_back(cycle);
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev_data  = out_data;
      end
   end

   initial begin
      logic [0:DATA_W-1] rnd;
      int                guard;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hdead_beef_0000_0001;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      $display("[TB] reset released, STAGES=%0d capacity=%0d", STAGES, CAP);

      // Streaming: back-to-back beats with downstream always ready.
      streaming_check = 1'b1;
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 64'(i), 1'b1, 1'b0);
      for (int i = 0; i < STAGES + 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      streaming_check = 1'b0;

      // Backpressure with a bubble between A and B.
      applyStimulus(1'b1, 64'h0A, 1'b0, 1'b0);
      applyStimulus(1'b0, '0,     1'b0, 1'b0);
      applyStimulus(1'b1, 64'h0B, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h0C, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h0D, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h0E, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Flush with two beats in flight and a valid input on the flush cycle.
      applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h12, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h13, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Fill to capacity, then push and pop together for four cycles.
      for (int i = 0; i < CAP; i++) applyStimulus(1'b1, 64'(32'h100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'(32'h200 + i), 1'b1, 1'b0);
      for (int i = 0; i < CAP + 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 1500; i++) begin
         rnd = {$urandom(), $urandom()};
         applyStimulus(($urandom_range(0, 9) < 7), rnd, ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 39) == 0));
      end

      // Drain with a bounded wait.
      guard = 0;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      while (exp_q.size() != 0 && guard < 50) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         guard++;
      end
      checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
